shift_reg_194: RTL and testbench
================================

SHIFT_REG_194 -- requirements
Module: shift_reg_194

Interface
REQ-001 Parameter: WIDTH, 8, register width in bits; legal range 2..16.
REQ-002 Port: C  input  1  clock; all state changes on rising edge only.
REQ-003 Port: R_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: S  input  2  mode select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-005 Port: DSR  input  1  serial data entering at Q[WIDTH-1] on shift right.
REQ-006 Port: DSL  input  1  serial data entering at Q[0] on shift left.
REQ-007 Port: D  input  WIDTH  parallel load data; typically fed from the upstream D-latch stage.
REQ-008 Port: Q  output  WIDTH  register contents.
REQ-009 Port: QS  output  1  serial out: Q[0] in shift-right mode, Q[WIDTH-1] in every other mode.
REQ-010 Port: CNT  output  4  count of shift operations since the last load or reset, modulo 16.
REQ-011 Port: WRAP  output  1  one-cycle pulse when CNT wraps from 15 to 0.
REQ-012 Port: CHG  output  1  high for one cycle after any edge that changed Q.

Function
REQ-013 The block SHALL be edge-triggered: D, DSR, DSL and S SHALL be sampled only at the rising edge of C, and input activity between edges SHALL NOT affect Q (no transparency, no multiple toggles per clock).
REQ-014 Hold (S=00): Q, CNT unchanged; WRAP=0.
REQ-015 Shift right (S=01): Q <= {DSR, Q[WIDTH-1:1]}; CNT <= CNT+1.
REQ-016 Shift left (S=10): Q <= {Q[WIDTH-2:0], DSL}; CNT <= CNT+1.
REQ-017 Load (S=11): Q <= D; CNT <= 0; WRAP <= 0.
REQ-018 Latency: Q reflects the new value one clock after the sampling edge (registered, no combinational path from D/DSR/DSL to Q).
REQ-019 CNT SHALL be 4-bit unsigned, wrapping 15->0 on the next shift; WRAP SHALL be 1 for exactly the cycle following the wrapping edge, else 0.
REQ-020 CHG SHALL be registered: 1 in the cycle after an edge where the new Q differs from the old Q, else 0; load of an identical value gives CHG=0.
REQ-021 QS SHALL be combinational from Q and S only.
REQ-022 An S value change between edges SHALL take effect at the next edge only; S=01 directly followed by S=10 SHALL shift right then left with no hold cycle inserted.
REQ-023 No X propagation: all outputs SHALL be defined after reset regardless of the input values applied before it.

Reset
REQ-024 R_n=0 SHALL immediately, without waiting for C, force Q=0, CNT=0, WRAP=0, CHG=0.
REQ-025 While R_n=0, clock edges SHALL be ignored.
REQ-026 Reset asserted mid-sequence (CNT nonzero, or a wrap pending) SHALL clear all state; no WRAP or CHG pulse SHALL appear after release.
REQ-027 The first edge after R_n rises SHALL be processed normally per S.

Verification
REQ-028 Reset then load: R_n=0 at 5 ns, release at 20 ns, S=11, D=8'hA5, one edge -> Q=8'hA5, CNT=0, CHG=1 for one cycle.
REQ-029 Shift right: from Q=8'hA5, S=01, DSR=1, 3 edges -> Q=8'hF4, CNT=3, QS=0.
REQ-030 Shift left with wrap: from Q=8'h01 after load, S=10, DSL=0, 16 edges -> Q=8'h00 after edge 8, CNT=0 after edge 16, WRAP=1 for exactly one cycle.
REQ-031 Edge-only sampling: S=11, C high, toggle D between 8'hFF and 8'h00 every 5 ns for 30 ns while C stays high -> Q changes only at the rising edges, to the D value present at each edge.
REQ-032 Async reset mid-operation: CNT=7, pull R_n low between edges -> Q=0, CNT=0 within the same cycle; edges during reset do not change Q.
REQ-033 Hold: S=00 for 10 edges with DSR/DSL/D toggling -> Q, CNT constant, CHG=0, WRAP=0.

Source files
------------

// File: rtl/shift_reg_194_if.sv
// ---------------------------------------------------------------------------
// shift_reg_194_if -- control and data bundle for the universal shift register.
//
// Signals
//   S     [1:0]       mode select: 00 hold, 01 shift right, 10 shift left,
//                     11 parallel load
//   DSR               serial input that enters at Q[WIDTH-1] on shift right
//   DSL               serial input that enters at Q[0] on shift left
//   D     [WIDTH-1:0] parallel load data
//   Q     [WIDTH-1:0] register contents
//   QS                serial output (Q[0] in shift-right mode, else Q[WIDTH-1])
//   CNT   [3:0]       shifts since last load/reset, modulo 16
//   WRAP              one-cycle pulse after CNT wraps 15 -> 0
//   CHG               one-cycle flag after an edge that changed Q
//
// Modports
//   master : the side that drives mode/data and observes the register
//   slave  : the register itself
// ---------------------------------------------------------------------------
interface shift_reg_194_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       S;
    logic             DSR;
    logic             DSL;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             QS;
    logic [3:0]       CNT;
    logic             WRAP;
    logic             CHG;

    modport master (
        output S, DSR, DSL, D,
        input  Q, QS, CNT, WRAP, CHG
    );

    modport slave (
        input  S, DSR, DSL, D,
        output Q, QS, CNT, WRAP, CHG
    );
endinterface

// File: rtl/shift_reg_194.sv
// ---------------------------------------------------------------------------
// shift_reg_194 -- WIDTH-bit universal shift register (hold / shift right /
// shift left / parallel load) with a shift counter, wrap pulse and
// change flag.
//
// Ports
//   C     in   clock, all state changes on the rising edge
//   R_n   in   asynchronous active-low reset; clears Q, CNT, WRAP, CHG
//   bus   slave modport of shift_reg_194_if (S, DSR, DSL, D in;
//              Q, QS, CNT, WRAP, CHG out)
//
// WIDTH must be in 2..16.
// ---------------------------------------------------------------------------
module shift_reg_194 #(
    parameter int WIDTH = 8
) (
    input  logic                 C,
    input  logic                 R_n,
    shift_reg_194_if.slave       bus
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] shl_val;
    logic [3:0]       cnt_r;
    logic [3:0]       cnt_nxt;
    logic             wrap_r;
    logic             wrap_nxt;
    logic             chg_r;
    logic             chg_nxt;
    logic             shifting;

    assign mode    = mode_e'(bus.S);
    assign shr_val = {bus.DSR, q_r[WIDTH-1:1]};
    assign shl_val = {q_r[WIDTH-2:0], bus.DSL};

    // Next-state selection. WRAP defaults low so it can only ever be a
    // single-cycle pulse following the shift that rolls CNT over.
    always_comb begin
        q_nxt    = q_r;
        cnt_nxt  = cnt_r;
        wrap_nxt = 1'b0;
        shifting = 1'b0;
        case (mode)
            MODE_SHR: begin
                q_nxt    = shr_val;
                shifting = 1'b1;
            end
            MODE_SHL: begin
                q_nxt    = shl_val;
                shifting = 1'b1;
            end
            MODE_LOAD: begin
                q_nxt   = bus.D;
                cnt_nxt = 4'd0;
            end
            default: begin
                q_nxt = q_r;
            end
        endcase
        if (shifting) begin
            cnt_nxt  = cnt_r + 4'd1;
            wrap_nxt = (cnt_r == 4'hF);
        end
        // Compares against the old value, so reloading identical data
        // leaves CHG low.
        chg_nxt = (q_nxt != q_r);
    end

    always_ff @(posedge C or negedge R_n) begin
        if (!R_n) begin
            q_r    <= '0;
            cnt_r  <= 4'd0;
            wrap_r <= 1'b0;
            chg_r  <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            cnt_r  <= cnt_nxt;
            wrap_r <= wrap_nxt;
            chg_r  <= chg_nxt;
        end
    end

    assign bus.Q    = q_r;
    assign bus.CNT  = cnt_r;
    assign bus.WRAP = wrap_r;
    assign bus.CHG  = chg_r;
    // Serial out follows the current mode select, not the registered mode:
    // it shows the bit that will leave on the next shift.
    assign bus.QS   = (bus.S == 2'b01) ? q_r[0] : q_r[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_194.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_194 -- directed bench for shift_reg_194 (WIDTH = 8).
// Inputs change on the falling edge; outputs are checked on the falling
// edge (or a few ns after an asynchronous event).
// ---------------------------------------------------------------------------
module tb_shift_reg_194;

    logic C   = 1'b0;
    logic R_n = 1'b1;
    bit   run = 1'b1;

    int checks = 0;
    int errors = 0;

    shift_reg_194_if #(.WIDTH(8)) bus ();

    shift_reg_194 #(.WIDTH(8)) dut (
        .C   (C),
        .R_n (R_n),
        .bus (bus.slave)
    );

    // Clock ticks every 5 ns; clearing run freezes C at its current level.
    always begin
        #5;
        if (run) C = ~C;
    end

    typedef struct {
        logic [1:0] s;
        logic       dsr;
        logic       dsl;
        logic [7:0] d;
        logic [7:0] q;
        logic [3:0] cnt;
        logic       wrap;
        logic       chg;
        logic       qs;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [7:0] eq, input logic [3:0] ecnt,
                       input logic ew, input logic ec, input logic eqs);
        checks++;
        if ({bus.Q, bus.CNT, bus.WRAP, bus.CHG, bus.QS} !== {eq, ecnt, ew, ec, eqs}) begin
            errors++;
            $display("FAIL %s: got Q=%h CNT=%0d WRAP=%b CHG=%b QS=%b, want Q=%h CNT=%0d WRAP=%b CHG=%b QS=%b",
                     name, bus.Q, bus.CNT, bus.WRAP, bus.CHG, bus.QS, eq, ecnt, ew, ec, eqs);
        end
    endtask

    task automatic step();
        @(posedge C);
        @(negedge C);
    endtask

    task automatic drive(input logic [1:0] s, input logic dsr, input logic dsl, input logic [7:0] d);
        bus.S   = s;
        bus.DSR = dsr;
        bus.DSL = dsl;
        bus.D   = d;
    endtask

    initial begin
        logic [7:0] e;

        tbl[0] = '{2'b01, 1'b1, 1'b0, 8'h00, 8'hD2, 4'd1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{2'b01, 1'b1, 1'b0, 8'h00, 8'hE9, 4'd2, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{2'b01, 1'b1, 1'b0, 8'h00, 8'hF4, 4'd3, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{2'b10, 1'b0, 1'b1, 8'h00, 8'hE9, 4'd4, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{2'b01, 1'b0, 1'b0, 8'h00, 8'h74, 4'd5, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{2'b00, 1'b1, 1'b1, 8'hFF, 8'h74, 4'd5, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{2'b11, 1'b0, 1'b0, 8'h74, 8'h74, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{2'b11, 1'b0, 1'b0, 8'h01, 8'h01, 4'd0, 1'b0, 1'b1, 1'b0};

        bus.S   = 2'bxx;
        bus.DSR = 1'bx;
        bus.DSL = 1'bx;
        bus.D   = 8'hxx;

        // Reset at 5 ns, edge at 15 ns while in reset, release at 20 ns.
        #5;
        R_n = 1'b0;
        drive(2'b11, 1'b0, 1'b0, 8'h3C);
        #2;
        chk("reset_async", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("reset_edge_ignored", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        R_n = 1'b1;
        bus.D = 8'hA5;
        step();
        chk("load_a5", 8'hA5, 4'd0, 1'b0, 1'b1, 1'b1);
        drive(2'b00, 1'b0, 1'b0, 8'h00);
        step();
        chk("chg_one_cycle", 8'hA5, 4'd0, 1'b0, 1'b0, 1'b1);

        // Shift right x3, direct right->left turn, hold, identical load, load.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].s, tbl[i].dsr, tbl[i].dsl, tbl[i].d);
            step();
            chk($sformatf("vec%0d", i), tbl[i].q, tbl[i].cnt, tbl[i].wrap, tbl[i].chg, tbl[i].qs);
        end

        // Shift left 16 times from 8'h01: empties after 8, CNT wraps at 16.
        drive(2'b10, 1'b0, 1'b0, 8'h00);
        e = 8'h01;
        for (int k = 1; k <= 16; k++) begin
            e = e << 1;
            step();
            chk($sformatf("shl_wrap_k%0d", k), e, 4'(k), (k == 16), (k <= 8), e[7]);
        end
        drive(2'b00, 1'b0, 1'b0, 8'h00);
        step();
        chk("wrap_clears", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

        // Build CNT=3 then hold 10 edges while inputs churn.
        drive(2'b11, 1'b0, 1'b0, 8'h5A);
        step();
        chk("load_5a", 8'h5A, 4'd0, 1'b0, 1'b1, 1'b0);
        drive(2'b01, 1'b0, 1'b0, 8'h00);
        step();
        chk("shr_2d", 8'h2D, 4'd1, 1'b0, 1'b1, 1'b1);
        step();
        step();
        chk("shr_0b", 8'h0B, 4'd3, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(2'b00, i[0], ~i[0], 8'(i * 37));
            #2 bus.D = ~bus.D;
            bus.DSR = ~bus.DSR;
            step();
            chk($sformatf("hold%0d", i), 8'h0B, 4'd3, 1'b0, 1'b0, 1'b0);
        end

        // Load FF, then freeze C high and churn D: Q must not follow.
        drive(2'b11, 1'b0, 1'b0, 8'hFF);
        @(posedge C);
        #1 run = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.D = i[0] ? 8'hFF : 8'h00;
            #1 chk($sformatf("clk_high%0d", i), 8'hFF, 4'd0, 1'b0, 1'b1, 1'b1);
            #4;
        end
        bus.D = 8'h00;
        run = 1'b1;
        @(negedge C);
        chk("before_restart_edge", 8'hFF, 4'd0, 1'b0, 1'b1, 1'b1);
        step();
        chk("restart_edge_load", 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);

        // Async reset with CNT=7.
        drive(2'b11, 1'b0, 1'b0, 8'h81);
        step();
        chk("load_81", 8'h81, 4'd0, 1'b0, 1'b1, 1'b1);
        drive(2'b01, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) step();
        chk("cnt7", 8'h01, 4'd7, 1'b0, 1'b1, 1'b1);
        #2 R_n = 1'b0;
        #1 chk("midop_reset", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        bus.DSR = 1'b1;
        step();
        step();
        chk("edges_in_reset", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        R_n = 1'b1;
        #1 chk("release_no_pulse", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("first_edge_after", 8'h80, 4'd1, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
